// File: rtl/fp_except_pipe.sv
// Two-stage, valid-qualified IEEE-754 operand exception classifier with sticky flags.
// Optional saturating NaN event counter enabled by defining FP_EXCEPT_CNT_EN.
module fp_except_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [EXP_W+FRAC_W:0]     opa,
    input  logic [EXP_W+FRAC_W:0]     opb,
    input  logic                      sticky_clr,
    output logic                      out_valid,
    output logic                      inf,
    output logic                      ind,
    output logic                      qnan,
    output logic                      snan,
    output logic                      opa_nan,
    output logic                      opb_nan,
    output logic                      opa_inf,
    output logic                      opb_inf,
    output logic                      opa_00,
    output logic                      opb_00,
    output logic                      opa_dn,
    output logic                      opb_dn,
    output logic [3:0]                sticky,
    output logic [CNT_W-1:0]          nan_cnt
);

    localparam int unsigned W = EXP_W + FRAC_W + 1;

    typedef struct packed {
        logic e_ones;
        logic e_zero;
        logic f_zero;
        logic f_msb;
        logic f_low;
    } dec_t;

    typedef struct packed {
        logic inf;
        logic ind;
        logic qnan;
        logic snan;
        logic opa_nan;
        logic opb_nan;
        logic opa_inf;
        logic opb_inf;
        logic opa_00;
        logic opb_00;
        logic opa_dn;
        logic opb_dn;
    } cls_t;

    // Sign never affects the classification.
    logic unused_sign;
    assign unused_sign = opa[W-1] ^ opb[W-1];

    function automatic dec_t decode(input logic [W-2:0] x);
        dec_t d;
        d.e_ones = &x[W-2 -: EXP_W];
        d.e_zero = ~|x[W-2 -: EXP_W];
        d.f_zero = ~|x[FRAC_W-1:0];
        d.f_msb  = x[FRAC_W-1];
        d.f_low  = |x[FRAC_W-2:0];
        return d;
    endfunction

    // Stage 1: raw field decodes.
    dec_t dec_a_d, dec_a_q;
    dec_t dec_b_d, dec_b_q;
    logic v1_d, v1_q;

    always_comb begin
        dec_a_d = decode(opa[W-2:0]);
        dec_b_d = decode(opb[W-2:0]);
        v1_d    = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_a_q <= '0;
            dec_b_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            dec_a_q <= dec_a_d;
            dec_b_q <= dec_b_d;
            v1_q    <= v1_d;
        end
    end

    // Stage 2: per-operand classes, combined and gated by v1 so idle cycles read as zero.
    logic a_inf, a_qnan, a_snan, a_nan, a_zero, a_dn;
    logic b_inf, b_qnan, b_snan, b_nan, b_zero, b_dn;
    cls_t cls_d, cls_q;
    logic out_valid_d, out_valid_q;

    always_comb begin
        a_inf  = dec_a_q.e_ones & dec_a_q.f_zero;
        a_qnan = dec_a_q.e_ones & dec_a_q.f_msb;
        a_snan = dec_a_q.e_ones & ~dec_a_q.f_msb & dec_a_q.f_low;
        a_nan  = dec_a_q.e_ones & ~dec_a_q.f_zero;
        a_zero = dec_a_q.e_zero & dec_a_q.f_zero;
        a_dn   = dec_a_q.e_zero;

        b_inf  = dec_b_q.e_ones & dec_b_q.f_zero;
        b_qnan = dec_b_q.e_ones & dec_b_q.f_msb;
        b_snan = dec_b_q.e_ones & ~dec_b_q.f_msb & dec_b_q.f_low;
        b_nan  = dec_b_q.e_ones & ~dec_b_q.f_zero;
        b_zero = dec_b_q.e_zero & dec_b_q.f_zero;
        b_dn   = dec_b_q.e_zero;

        cls_d         = '0;
        cls_d.inf     = v1_q & (a_inf | b_inf);
        cls_d.ind     = v1_q & a_inf & b_inf;
        cls_d.qnan    = v1_q & (a_qnan | b_qnan);
        cls_d.snan    = v1_q & (a_snan | b_snan);
        cls_d.opa_nan = v1_q & a_nan;
        cls_d.opb_nan = v1_q & b_nan;
        cls_d.opa_inf = v1_q & a_inf;
        cls_d.opb_inf = v1_q & b_inf;
        cls_d.opa_00  = v1_q & a_zero;
        cls_d.opb_00  = v1_q & b_zero;
        cls_d.opa_dn  = v1_q & a_dn;
        cls_d.opb_dn  = v1_q & b_dn;

        out_valid_d = v1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cls_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cls_q       <= cls_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Sticky accumulation; a clear reloads with the current event so nothing is lost.
    logic [3:0] ev;
    logic [3:0] sticky_d, sticky_q;

    always_comb begin
        ev = {cls_q.snan, cls_q.qnan, cls_q.ind, cls_q.inf};
        if (sticky_clr) begin
            sticky_d = ev;
        end else begin
            sticky_d = sticky_q | ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

`ifdef FP_EXCEPT_CNT_EN
    logic                 nan_ev;
    logic [CNT_W-1:0]     nan_cnt_d, nan_cnt_q;

    always_comb begin
        nan_ev    = cls_q.qnan | cls_q.snan;
        nan_cnt_d = nan_cnt_q;
        if (sticky_clr) begin
            nan_cnt_d = CNT_W'(nan_ev);
        end else if (nan_ev && (nan_cnt_q != {CNT_W{1'b1}})) begin
            nan_cnt_d = nan_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nan_cnt_q <= '0;
        end else begin
            nan_cnt_q <= nan_cnt_d;
        end
    end

    assign nan_cnt = nan_cnt_q;
`else
    assign nan_cnt = '0;
`endif

    assign out_valid = out_valid_q;
    assign inf       = cls_q.inf;
    assign ind       = cls_q.ind;
    assign qnan      = cls_q.qnan;
    assign snan      = cls_q.snan;
    assign opa_nan   = cls_q.opa_nan;
    assign opb_nan   = cls_q.opb_nan;
    assign opa_inf   = cls_q.opa_inf;
    assign opb_inf   = cls_q.opb_inf;
    assign opa_00    = cls_q.opa_00;
    assign opb_00    = cls_q.opb_00;
    assign opa_dn    = cls_q.opa_dn;
    assign opb_dn    = cls_q.opb_dn;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_fp_except_pipe.sv
// Scoreboard bench for fp_except_pipe: single-precision instance plus a double-precision
// instance with a 4-bit counter for the saturation case.
module tb_fp_except_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] opa, opb;
    logic        sticky_clr;
    logic        out_valid, inf, ind, qnan, snan, opa_nan, opb_nan, opa_inf, opb_inf;
    logic        opa_00, opb_00, opa_dn, opb_dn;
    logic [3:0]  sticky;
    logic [15:0] nan_cnt;

    logic        dp_valid;
    logic [63:0] dp_a, dp_b;
    logic        dp_out_valid, dp_inf, dp_ind, dp_qnan, dp_snan, dp_opa_nan, dp_opb_nan;
    logic        dp_opa_inf, dp_opb_inf, dp_opa_00, dp_opb_00, dp_opa_dn, dp_opb_dn;
    logic [3:0]  dp_sticky;
    logic [3:0]  dp_nan_cnt;

    always #5 clk = ~clk;

    fp_except_pipe u_sp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opa(opa), .opb(opb),
        .sticky_clr(sticky_clr), .out_valid(out_valid), .inf(inf), .ind(ind), .qnan(qnan),
        .snan(snan), .opa_nan(opa_nan), .opb_nan(opb_nan), .opa_inf(opa_inf),
        .opb_inf(opb_inf), .opa_00(opa_00), .opb_00(opb_00), .opa_dn(opa_dn),
        .opb_dn(opb_dn), .sticky(sticky), .nan_cnt(nan_cnt)
    );

    fp_except_pipe #(.EXP_W(11), .FRAC_W(52), .CNT_W(4)) u_dp (
        .clk(clk), .rst(rst), .in_valid(dp_valid), .opa(dp_a), .opb(dp_b),
        .sticky_clr(1'b0), .out_valid(dp_out_valid), .inf(dp_inf), .ind(dp_ind),
        .qnan(dp_qnan), .snan(dp_snan), .opa_nan(dp_opa_nan), .opb_nan(dp_opb_nan),
        .opa_inf(dp_opa_inf), .opb_inf(dp_opb_inf), .opa_00(dp_opa_00), .opb_00(dp_opb_00),
        .opa_dn(dp_opa_dn), .opb_dn(dp_opb_dn), .sticky(dp_sticky), .nan_cnt(dp_nan_cnt)
    );

    typedef struct {
        int          cyc;
        logic [11:0] cls;
    } exp_t;

    exp_t q[$];
    int   dq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0]  m_sticky = 4'b0;
    logic [15:0] m_cnt = 16'd0;
    logic [3:0]  m_dsticky = 4'b0;
    logic [3:0]  m_dcnt = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference classification, bit order {inf,ind,qnan,snan,a_nan,b_nan,a_inf,b_inf,a_00,b_00,a_dn,b_dn}.
    function automatic logic [11:0] classify(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic ia, ib, qa, qb, sa, sb, na, nb, za, zb, da, db;
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        ia = (ea == 8'hFF) && (fa == 23'd0);
        ib = (eb == 8'hFF) && (fb == 23'd0);
        qa = (ea == 8'hFF) && fa[22];
        qb = (eb == 8'hFF) && fb[22];
        sa = (ea == 8'hFF) && !fa[22] && (fa != 23'd0);
        sb = (eb == 8'hFF) && !fb[22] && (fb != 23'd0);
        na = (ea == 8'hFF) && (fa != 23'd0);
        nb = (eb == 8'hFF) && (fb != 23'd0);
        za = (ea == 8'd0) && (fa == 23'd0);
        zb = (eb == 8'd0) && (fb == 23'd0);
        da = (ea == 8'd0);
        db = (eb == 8'd0);
        return {ia | ib, ia & ib, qa | qb, sa | sb, na, nb, ia, ib, za, zb, da, db};
    endfunction

    // Monitor: compare the cycle's outputs, then advance the sticky/counter models.
    always @(negedge clk) begin
        logic [11:0] e;
        logic        hit, dhit;
        logic [3:0]  ev;
        if (cyc > 0) begin
            hit = (q.size() > 0) && (q[0].cyc == cyc);
            e   = hit ? q[0].cls : 12'd0;
            check("out_valid", {63'd0, out_valid}, {63'd0, hit});
            check("flags", {52'd0, inf, ind, qnan, snan, opa_nan, opb_nan, opa_inf, opb_inf,
                            opa_00, opb_00, opa_dn, opb_dn}, {52'd0, e});
            check("sticky", {60'd0, sticky}, {60'd0, m_sticky});
            check("nan_cnt", {48'd0, nan_cnt}, {48'd0, m_cnt});
            if (hit) void'(q.pop_front());
            ev = {e[8], e[9], e[10], e[11]};
            if (rst) begin
                m_sticky = 4'b0;
                m_cnt    = 16'd0;
                q.delete();
            end else begin
                m_sticky = sticky_clr ? ev : (m_sticky | ev);
`ifdef FP_EXCEPT_CNT_EN
                if (sticky_clr) m_cnt = {15'd0, ev[3] | ev[2]};
                else if ((ev[3] | ev[2]) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end

            dhit = (dq.size() > 0) && (dq[0] == cyc);
            check("dp_class", {55'd0, dp_out_valid, dp_inf, dp_ind, dp_qnan, dp_snan,
                               dp_opa_nan, dp_opb_nan, dp_opa_dn, dp_opb_dn},
                  {55'd0, dhit, 1'b0, 1'b0, 1'b0, dhit, dhit, 1'b0, 1'b0, 1'b0});
            check("dp_sticky", {60'd0, dp_sticky}, {60'd0, m_dsticky});
            check("dp_nan_cnt", {60'd0, dp_nan_cnt}, {60'd0, m_dcnt});
            if (dhit) void'(dq.pop_front());
            if (rst) begin
                m_dsticky = 4'b0;
                m_dcnt    = 4'd0;
                dq.delete();
            end else if (dhit) begin
                m_dsticky = m_dsticky | 4'b1000;
`ifdef FP_EXCEPT_CNT_EN
                if (m_dcnt != 4'hF) m_dcnt = m_dcnt + 4'd1;
`endif
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, input logic r, input logic dv);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid   = v;
        opa        = a;
        opb        = b;
        sticky_clr = clr;
        rst        = r;
        dp_valid   = dv;
        if (v && !r) begin
            x.cyc = cyc + 2;
            x.cls = classify(a, b);
            q.push_back(x);
        end
        if (dv && !r) dq.push_back(cyc + 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q.size() > 0 || dq.size() > 0) && budget < 20) begin
            idle(1);
            budget++;
        end
        check("drain", {32'd0, 32'(q.size() + dq.size())}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        sticky_clr = 1'b0;
        dp_valid   = 1'b0;
        dp_a       = 64'h7FF0000000000001;
        dp_b       = 64'h3FF0000000000000;

        // in_valid during reset must be ignored
        step(1'b1, 32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1'b0);
        idle(3);

        // +INF with a normal operand; flags drop the following cycle
        step(1'b1, 32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        idle(3);
        // -INF and +INF: invalid-operation pair
        step(1'b1, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 1'b0);
        idle(3);
        // QNAN and SNAN, with sticky cleared in the output cycle
        step(1'b1, 32'h7FC00000, 32'h7F800001, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("sticky_after_clr", {60'd0, sticky}, {60'd0, 4'b1100});
        // zero and denormal
        step(1'b1, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
        // back-to-back mix, sign variants and fraction-MSB boundaries
        step(1'b1, 32'h80000000, 32'hFFC00001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7FBFFFFF, 32'h00800000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 32'h807FFFFF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 1'b0);
        drain();

        // reset mid-burst discards everything in flight
        step(1'b1, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7FC00000, 32'h7F800001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hFF800000, 32'h00000000, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("post_reset_sticky", {60'd0, sticky}, 64'd0);

        // double precision SNAN for 17 cycles; counter saturates when enabled
        for (int i = 0; i < 17; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        drain();
`ifdef FP_EXCEPT_CNT_EN
        check("dp_saturated", {60'd0, dp_nan_cnt}, {60'd0, 4'hF});
`else
        check("dp_cnt_tied", {60'd0, dp_nan_cnt}, 64'd0);
`endif
        check("dp_sticky_final", {60'd0, dp_sticky}, {60'd0, 4'b1000});

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
